pattern_fill: RTL
=================

PATTERN_FILL -- requirements
Module: pattern_fill

Interface
REQ-001 SHALL have parameter HDISP, default 800, frame width in pixels; HDISP must be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter VDISP, default 480, frame height in lines; VDISP must be at least 1.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address of pixel (0,0) in SDRAM; BASE_ADDR must be 4-byte aligned.
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk  in  1  system clock (sys_clk domain).
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle fill request.
REQ-007 pattern_sel  in  2  pattern select, sampled with start.
REQ-008 fill_color  in  24  {R,G,B} for pattern 3, sampled with start.
REQ-009 busy  out  1  high while a frame fill is in progress.
REQ-010 done  out  1  one-cycle pulse after the last pixel is accepted.
REQ-011 address  out  32  Avalon-MM byte address.
REQ-012 write  out  1  Avalon-MM write request.
REQ-013 writedata  out  32  pixel word {8'h00,R,G,B}.
REQ-014 byteenable  out  4  constant 4'hF.
REQ-015 read  out  1  constant 0.
REQ-016 waitrequest  in  1  Avalon-MM slave stall.

Function
REQ-017 SHALL implement FSM IDLE -> FILL -> IDLE; busy=1 exactly in FILL.
REQ-018 In IDLE, start=1 SHALL latch pattern_sel/fill_color, clear x,y to 0, enter FILL; write=1 with pixel (0,0) on the next cycle.
REQ-019 start while in FILL SHALL be ignored (no restart, no re-latch).
REQ-020 A write is accepted on a cycle with write=1 and waitrequest=0; while waitrequest=1, address/writedata/write SHALL hold stable.
REQ-021 Throughput SHALL be one pixel per cycle while waitrequest=0; no idle cycles between pixels.
REQ-022 Pixel order raster: x 0..HDISP-1 then y+1, x wraps to 0; y 0..VDISP-1.
REQ-023 address SHALL equal BASE_ADDR + 4*(y*HDISP + x), computed incrementally (+4 per accept), no multiplier.
REQ-024 Pattern 0 (colour bars): bar b in 0..7 increments every HDISP/8 pixels along x, resets at x=0; R=b[2]?FF:00, G=b[1]?FF:00, B=b[0]?FF:00.
REQ-025 Pattern 1 (checkerboard): pixel = 24'hFFFFFF if x[4]^y[4] else 24'h000000.
REQ-026 Pattern 2 (gradient): R=G=B=x[7:0] (wraps every 256 pixels).
REQ-027 Pattern 3 (solid): pixel = latched fill_color.
REQ-028 On acceptance of pixel (HDISP-1,VDISP-1): next cycle write=0, done=1 for one cycle, state IDLE, busy=0.
REQ-029 start coincident with done (cycle state returns to IDLE) SHALL be ignored; a start one cycle after done is honoured.
REQ-030 x, y counters SHALL be sized $clog2(HDISP), $clog2(VDISP) bits minimum; no overflow beyond frame bounds.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, write=0, address=BASE_ADDR, writedata=0, x=y=0, bar=0.
REQ-032 rst mid-fill SHALL abort immediately (write=0 the next cycle, no done pulse); subsequent start restarts from (0,0).
REQ-033 byteenable=4'hF and read=0 SHALL hold in and out of reset.

Verification (bench params HDISP=32, VDISP=2, BASE_ADDR=32'h1000)
REQ-034 start, sel=3, color=24'h123456, waitrequest=0 -> 64 consecutive writes, addresses 0x1000..0x10FC step 4, data 0x00123456, done pulse cycle after last, busy low.
REQ-035 sel=0, waitrequest=0 -> pixels x=0..3 data 0x00000000, x=4..7 0x000000FF, x=28..31 0x00FFFFFF, bar resets at x=0 of line 1.
REQ-036 sel=1 -> line 0: x=0..15 0x000000, x=16..31 0xFFFFFF; sel=2 -> pixel x=31 data 0x001F1F1F.
REQ-037 sel=3, waitrequest high 3 cycles on pixel 5 -> address 0x1014 and data held stable 4 cycles, total 64 accepted, no pixel lost or duplicated.
REQ-038 rst asserted after 10 accepts -> write=0 next cycle, no done; new start -> first write address 0x1000.
REQ-039 start asserted during FILL and on the done cycle -> no restart; exactly one done pulse per honoured start.

Source files
------------

// File: rtl/pattern_fill_if.sv
// Avalon-MM write-master bundle between the pattern generator and SDRAM.
// The master drives the request side, the slave stalls with waitrequest.
interface pattern_fill_if;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic        waitrequest;

    modport master (
        output address,
        output write,
        output writedata,
        output byteenable,
        output read,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  byteenable,
        input  read,
        output waitrequest
    );
endinterface

// File: rtl/pattern_fill.sv
// Frame filler: streams one test-pattern pixel per cycle into SDRAM
// in raster order over an Avalon-MM write master.
module pattern_fill #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] fill_color,
    output logic        busy,
    output logic        done,
    pattern_fill_if.master av
);
    localparam int XW  = $clog2(HDISP);
    localparam int YW  = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BPW = HDISP / 8;
    localparam int CW  = $clog2(BPW + 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]  bar;
    logic [CW-1:0] bar_cnt;
    logic [31:0] addr_q;
    logic [1:0]  sel_q;
    logic [23:0] color_q;
    logic [23:0] pixel;
    logic        launch;
    logic        accept;
    logic        x_end;
    logic        last;
    logic        x4;
    logic        y4;
    logic [7:0]  grad;

    // A start on the done cycle is dropped so a frame never re-arms itself
    assign launch = (state == IDLE) && start && !done;
    assign accept = (state == FILL) && !av.waitrequest;
    assign x_end  = (x == XW'(HDISP - 1));
    assign last   = accept && x_end && (y == YW'(VDISP - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = FILL;
            FILL:    if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            bar     <= '0;
            bar_cnt <= '0;
            addr_q  <= BASE_ADDR;
            sel_q   <= '0;
            color_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= last;
            if (launch) begin
                x       <= '0;
                y       <= '0;
                bar     <= '0;
                bar_cnt <= '0;
                addr_q  <= BASE_ADDR;
                sel_q   <= pattern_sel;
                color_q <= fill_color;
            end else if (accept && !last) begin
                addr_q <= addr_q + 32'd4;
                if (x_end) begin
                    x       <= '0;
                    y       <= y + 1'b1;
                    bar     <= '0;
                    bar_cnt <= '0;
                end else begin
                    x <= x + 1'b1;
                    if (bar_cnt == CW'(BPW - 1)) begin
                        bar_cnt <= '0;
                        bar     <= bar + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign x4   = 1'((32'(x) >> 4));
    assign y4   = 1'((32'(y) >> 4));
    assign grad = 8'(x);

    always_comb begin
        pixel = '0;
        unique case (sel_q)
            2'd0: pixel = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            2'd1: pixel = {24{x4 ^ y4}};
            2'd2: pixel = {grad, grad, grad};
            default: pixel = color_q;
        endcase
    end

    assign busy          = (state == FILL);
    assign av.write      = (state == FILL);
    assign av.address    = addr_q;
    assign av.writedata  = (state == FILL) ? {8'h00, pixel} : 32'h0;
    assign av.byteenable = 4'hF;
    assign av.read       = 1'b0;
endmodule
